// File: rtl/lane_vrf_write_arbiter_if.sv
// lane_vrf_write_arbiter_if
//   Bundles the write-source request bus, the VRF write request, and the
//   per-instruction completion/pending vectors of one lane's VRF write arbiter.
//   Signals:
//     req_valid/req_ready              per-source handshake (NUM_REQ bits)
//     req_vd/req_mask/req_data         per-source payload, source i in slice i
//     req_last/req_instructionIndex    per-source end-of-instruction flag and tag
//     vrfWriteRequest_*                single VRF write port (valid/ready + bits)
//     instructionFinished              one-cycle pulse per finished instruction tag
//     writePending                     tag of the write held in the output register
//   Modports: master = arbiter side, slave = sources/VRF side.
interface lane_vrf_write_arbiter_if #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned VD_W    = 5,
   parameter int unsigned DATA_W  = 32
);
   localparam int unsigned MASK_W = DATA_W / 8;

   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ-1:0]        req_ready;
   logic [NUM_REQ*VD_W-1:0]   req_vd;
   logic [NUM_REQ*MASK_W-1:0] req_mask;
   logic [NUM_REQ*DATA_W-1:0] req_data;
   logic [NUM_REQ-1:0]        req_last;
   logic [NUM_REQ*3-1:0]      req_instructionIndex;

   logic                      vrfWriteRequest_ready;
   logic                      vrfWriteRequest_valid;
   logic [VD_W-1:0]           vrfWriteRequest_bits_vd;
   logic [MASK_W-1:0]         vrfWriteRequest_bits_mask;
   logic [DATA_W-1:0]         vrfWriteRequest_bits_data;
   logic                      vrfWriteRequest_bits_last;
   logic [2:0]                vrfWriteRequest_bits_instructionIndex;

   logic [7:0]                instructionFinished;
   logic [7:0]                writePending;

   modport master (
      input  req_valid, req_vd, req_mask, req_data, req_last, req_instructionIndex,
      input  vrfWriteRequest_ready,
      output req_ready,
      output vrfWriteRequest_valid, vrfWriteRequest_bits_vd, vrfWriteRequest_bits_mask,
      output vrfWriteRequest_bits_data, vrfWriteRequest_bits_last,
      output vrfWriteRequest_bits_instructionIndex,
      output instructionFinished, writePending
   );

   modport slave (
      output req_valid, req_vd, req_mask, req_data, req_last, req_instructionIndex,
      output vrfWriteRequest_ready,
      input  req_ready,
      input  vrfWriteRequest_valid, vrfWriteRequest_bits_vd, vrfWriteRequest_bits_mask,
      input  vrfWriteRequest_bits_data, vrfWriteRequest_bits_last,
      input  vrfWriteRequest_bits_instructionIndex,
      input  instructionFinished, writePending
   );
endinterface

// File: rtl/lane_vrf_write_arbiter.sv
// lane_vrf_write_arbiter
//   Shares one lane's VRF write port among NUM_REQ write sources using
//   round-robin arbitration into a one-entry output register, and reports
//   per-instruction write completion.
//   Ports:
//     clock  rising-edge clock
//     reset  synchronous active-high reset
//     bus    lane_vrf_write_arbiter_if.master (requests, VRF write, status)
//   Optional feature: define LANE_VRF_ARB_PRIO0_EN to give requester 0
//   (cross-lane write) absolute priority; 1..NUM_REQ-1 round-robin when 0 idles.
module lane_vrf_write_arbiter #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned VD_W    = 5,
   parameter int unsigned DATA_W  = 32
) (
   input  logic clock,
   input  logic reset,
   lane_vrf_write_arbiter_if.master bus
);
   localparam int unsigned MASK_W = DATA_W / 8;
   localparam int unsigned IDX_W  = $clog2(NUM_REQ);

   logic              r_valid;
   logic [VD_W-1:0]   r_vd;
   logic [MASK_W-1:0] r_mask;
   logic [DATA_W-1:0] r_data;
   logic              r_last;
   logic [2:0]        r_idx;
   logic [IDX_W-1:0]  r_rr_ptr;
   logic [7:0]        r_fin;

   logic              w_hs;
   logic              w_free;
   logic              w_hit;
   logic              w_grant;
   logic              w_upd_rr;
   int unsigned       w_sel;
   logic [IDX_W-1:0]  w_rr_next;

   assign w_hs   = r_valid && bus.vrfWriteRequest_ready;
   assign w_free = !r_valid || bus.vrfWriteRequest_ready;

   // Winner search: scan NUM_REQ slots starting at r_rr_ptr, wrapping to 0.
   always_comb begin
      int unsigned v_i;
      v_i      = 0;
      w_hit    = 1'b0;
      w_sel    = 0;
      w_upd_rr = 1'b1;
`ifdef LANE_VRF_ARB_PRIO0_EN
      if (bus.req_valid[0]) begin
         w_hit    = 1'b1;
         w_sel    = 0;
         w_upd_rr = 1'b0;
      end else begin
         for (int unsigned k = 0; k < NUM_REQ; k++) begin
            v_i = (32'(r_rr_ptr) + k) % NUM_REQ;
            if (!w_hit && v_i != 0 && bus.req_valid[v_i]) begin
               w_hit = 1'b1;
               w_sel = v_i;
            end
         end
      end
`else
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         v_i = (32'(r_rr_ptr) + k) % NUM_REQ;
         if (!w_hit && bus.req_valid[v_i]) begin
            w_hit = 1'b1;
            w_sel = v_i;
         end
      end
`endif
   end

   assign w_grant   = w_hit && w_free;
   assign w_rr_next = IDX_W'((w_sel + 1) % NUM_REQ);

   always_comb begin
      bus.req_ready = '0;
      if (w_grant) begin
         bus.req_ready[w_sel] = 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_valid  <= 1'b0;
         r_vd     <= '0;
         r_mask   <= '0;
         r_data   <= '0;
         r_last   <= 1'b0;
         r_idx    <= '0;
         r_rr_ptr <= '0;
         r_fin    <= '0;
      end else begin
         r_fin <= (w_hs && r_last) ? (8'd1 << r_idx) : '0;
         // A grant reloads the register even when it drains this same cycle.
         if (w_grant) begin
            r_valid <= 1'b1;
            r_vd    <= bus.req_vd[w_sel*VD_W +: VD_W];
            r_mask  <= bus.req_mask[w_sel*MASK_W +: MASK_W];
            r_data  <= bus.req_data[w_sel*DATA_W +: DATA_W];
            r_last  <= bus.req_last[w_sel];
            r_idx   <= bus.req_instructionIndex[w_sel*3 +: 3];
            if (w_upd_rr) begin
               r_rr_ptr <= w_rr_next;
            end
         end else if (w_hs) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign bus.vrfWriteRequest_valid                = r_valid;
   assign bus.vrfWriteRequest_bits_vd              = r_vd;
   assign bus.vrfWriteRequest_bits_mask            = r_mask;
   assign bus.vrfWriteRequest_bits_data            = r_data;
   assign bus.vrfWriteRequest_bits_last            = r_last;
   assign bus.vrfWriteRequest_bits_instructionIndex = r_idx;
   assign bus.instructionFinished                  = r_fin;
   assign bus.writePending                         = r_valid ? (8'd1 << r_idx) : '0;
endmodule

// File: tb/tb_lane_vrf_write_arbiter.sv
// tb_lane_vrf_write_arbiter
//   Directed self-checking bench for lane_vrf_write_arbiter (NUM_REQ=4,
//   VD_W=5, DATA_W=32). Inputs change 1 time unit after the rising edge;
//   outputs are sampled before the next rising edge.
module tb_lane_vrf_write_arbiter;
   logic clock = 1'b0;
   logic reset = 1'b1;
   int   n_assert = 0;
   int   n_fail   = 0;

   lane_vrf_write_arbiter_if #(.NUM_REQ(4), .VD_W(5), .DATA_W(32)) bus ();

   lane_vrf_write_arbiter #(.NUM_REQ(4), .VD_W(5), .DATA_W(32)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      n_assert++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      bus.req_valid = '0;
      bus.vrfWriteRequest_ready = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic std_payload();
      bus.req_vd   = {5'd13, 5'd12, 5'd11, 5'd10};
      bus.req_data = {32'hA000_0003, 32'hA000_0002, 32'hA000_0001, 32'hA000_0000};
      bus.req_mask = 16'hFFFF;
      bus.req_last = 4'b0000;
      bus.req_instructionIndex = '0;
   endtask

   localparam logic [3:0] FOLLOW_EXP =
`ifdef LANE_VRF_ARB_PRIO0_EN
      4'b0010;
`else
      4'b1000;
`endif

   initial begin
      logic [3:0] exp_rdy;
      bus.req_valid = '0;
      bus.vrfWriteRequest_ready = 1'b1;
      std_payload();

      // Reset state
      do_reset();
      #1;
      chk("rst_valid",   64'(bus.vrfWriteRequest_valid), 64'd0);
      chk("rst_vd",      64'(bus.vrfWriteRequest_bits_vd), 64'd0);
      chk("rst_data",    64'(bus.vrfWriteRequest_bits_data), 64'd0);
      chk("rst_fin",     64'(bus.instructionFinished), 64'd0);
      chk("rst_pending", 64'(bus.writePending), 64'd0);
      chk("rst_ready",   64'(bus.req_ready), 64'd0);

      // Single request from source 2
      bus.req_vd   = {5'd0, 5'd7, 5'd0, 5'd0};
      bus.req_data = {32'h0, 32'hDEAD_BEEF, 32'h0, 32'h0};
      bus.req_mask = {4'h0, 4'hA, 4'h0, 4'h0};
      bus.req_valid = 4'b0100;
      #1;
      chk("t1_grant", 64'(bus.req_ready), 64'h4);
      tick();
      bus.req_valid = 4'b0000;
      #1;
      chk("t1_valid", 64'(bus.vrfWriteRequest_valid), 64'd1);
      chk("t1_vd",    64'(bus.vrfWriteRequest_bits_vd), 64'd7);
      chk("t1_data",  64'(bus.vrfWriteRequest_bits_data), 64'hDEAD_BEEF);
      chk("t1_mask",  64'(bus.vrfWriteRequest_bits_mask), 64'hA);
      chk("t1_last",  64'(bus.vrfWriteRequest_bits_last), 64'd0);
      // rr_ptr is now 3, so an all-valid request goes to source 3
      bus.req_valid = 4'b1111;
      #1;
      chk("t1_rrptr3", 64'(bus.req_ready), 64'h8);

      // Fairness with everyone valid and VRF always ready
      do_reset();
      std_payload();
      bus.req_valid = 4'b1111;
      for (int k = 0; k < 8; k++) begin
         #1;
         exp_rdy = 4'b0001 << (k % 4);
         chk($sformatf("rr_grant%0d", k), 64'(bus.req_ready), 64'(exp_rdy));
         if (k > 0) begin
            chk($sformatf("rr_valid%0d", k), 64'(bus.vrfWriteRequest_valid), 64'd1);
            chk($sformatf("rr_vd%0d", k), 64'(bus.vrfWriteRequest_bits_vd), 64'(10 + ((k - 1) % 4)));
         end
         tick();
      end

      // Backpressure
      do_reset();
      std_payload();
      bus.req_valid = 4'b0011;
      #1;
      chk("bp_grant0", 64'(bus.req_ready), 64'h1);
      tick();
      bus.vrfWriteRequest_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         #1;
         chk($sformatf("bp_ready%0d", k), 64'(bus.req_ready), 64'h0);
         chk($sformatf("bp_valid%0d", k), 64'(bus.vrfWriteRequest_valid), 64'd1);
         chk($sformatf("bp_vd%0d", k), 64'(bus.vrfWriteRequest_bits_vd), 64'd10);
         chk($sformatf("bp_data%0d", k), 64'(bus.vrfWriteRequest_bits_data), 64'hA000_0000);
         tick();
      end
      bus.vrfWriteRequest_ready = 1'b1;
      #1;
      chk("bp_regrant", 64'(bus.req_ready), 64'h2);
      tick();
      bus.req_valid = 4'b0000;
      #1;
      chk("bp_next_vd",    64'(bus.vrfWriteRequest_bits_vd), 64'd11);
      chk("bp_next_valid", 64'(bus.vrfWriteRequest_valid), 64'd1);

      // Instruction completion
      do_reset();
      std_payload();
      bus.req_last = 4'b0010;
      bus.req_instructionIndex = {3'd0, 3'd0, 3'd5, 3'd0};
      bus.vrfWriteRequest_ready = 1'b0;
      bus.req_valid = 4'b0010;
      #1;
      chk("fin_grant", 64'(bus.req_ready), 64'h2);
      tick();                                  // cycle 1
      bus.req_valid = 4'b0000;
      #1;
      chk("fin_pend1", 64'(bus.writePending), 64'h20);
      chk("fin_fin1",  64'(bus.instructionFinished), 64'h0);
      chk("fin_last1", 64'(bus.vrfWriteRequest_bits_last), 64'd1);
      tick();                                  // cycle 2
      chk("fin_pend2", 64'(bus.writePending), 64'h20);
      tick();                                  // cycle 3: accepted
      bus.vrfWriteRequest_ready = 1'b1;
      #1;
      chk("fin_fin3",  64'(bus.instructionFinished), 64'h0);
      chk("fin_pend3", 64'(bus.writePending), 64'h20);
      tick();                                  // cycle 4
      chk("fin_fin4",   64'(bus.instructionFinished), 64'h20);
      chk("fin_pend4",  64'(bus.writePending), 64'h0);
      chk("fin_valid4", 64'(bus.vrfWriteRequest_valid), 64'd0);
      tick();                                  // cycle 5
      chk("fin_fin5", 64'(bus.instructionFinished), 64'h0);

      // Reset while holding a last write
      do_reset();
      bus.req_valid = 4'b0010;
      bus.vrfWriteRequest_ready = 1'b0;
      tick();
      bus.req_valid = 4'b0000;
      #1;
      chk("mr_valid_before", 64'(bus.vrfWriteRequest_valid), 64'd1);
      reset = 1'b1;
      bus.vrfWriteRequest_ready = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      chk("mr_valid", 64'(bus.vrfWriteRequest_valid), 64'd0);
      chk("mr_fin",   64'(bus.instructionFinished), 64'h0);
      chk("mr_pend",  64'(bus.writePending), 64'h0);
      tick();
      chk("mr_fin2",  64'(bus.instructionFinished), 64'h0);
      bus.req_valid = 4'b1111;
      #1;
      chk("mr_first_grant", 64'(bus.req_ready), 64'h1);

      // Sources 0 and 2 continuously valid
      do_reset();
      std_payload();
      bus.req_valid = 4'b0101;
      for (int k = 0; k < 4; k++) begin
         #1;
`ifdef LANE_VRF_ARB_PRIO0_EN
         exp_rdy = 4'b0001;
`else
         exp_rdy = (k % 2 == 0) ? 4'b0001 : 4'b0100;
`endif
         chk($sformatf("p0_grant%0d", k), 64'(bus.req_ready), 64'(exp_rdy));
         tick();
      end
      // Round-robin pointer after the 0/2 sequence
      bus.req_valid = 4'b1110;
      #1;
      chk("p0_follow", 64'(bus.req_ready), 64'(FOLLOW_EXP));
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
